// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file slice.
package regfile_pkg;

  typedef enum logic {
    IDLE,
    SWEEP
  } clr_state_t;

  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  // Low bit index of port `port` inside a flat bus of `w`-bit fields.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_pend;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output ra, we, wa, wd, sb_set, sb_addr, clr_req,
    input  rd, rd_pend, clr_busy
  );

  modport slave (
    input  ra, we, wa, wd, sb_set, sb_addr, clr_req,
    output rd, rd_pend, clr_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bits for in-flight loads; set beats clear, flush empties all.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_REGS-1:0]      clr_vec,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  input  logic [NUM_RD-1:0]        rd_mask,
  output logic [NUM_RD-1:0]        rd_pend
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_W-1:0]   ra_a [NUM_RD];

  always_comb begin
    pend_nxt = pend & ~clr_vec;
    if (set_en) pend_nxt[set_addr] = 1'b1;
    pend_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) pend <= '0;
    else              pend <= pend_nxt;
  end

  always_comb begin
    rd_pend = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra_a[i]    = ra[slice_lo(i, ADDR_W) +: ADDR_W];
      rd_pend[i] = pend[ra_a[i]] && (ra_a[i] != '0) && !rd_mask[i];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with load scoreboard and sequential clear sweep.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(NUM_REGS - 1);

  clr_state_t        state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [ADDR_W-1:0] ra_a [NUM_RD];
  logic [DATA_W-1:0] rd_a [NUM_RD];
  logic [ADDR_W-1:0] wa_a [NUM_WR];
  logic [DATA_W-1:0] wd_a [NUM_WR];

  logic                idle;
  logic                wr_ok;
  logic [NUM_WR-1:0]   wr_go;
  logic [NUM_REGS-1:0] wr_clr;
  logic [NUM_RD-1:0]   byp_hit;
  logic                sb_flush;
  logic                sb_set_ok;

  // A clr_req in IDLE drops same-cycle writes and scoreboard sets.
  assign idle      = (state == IDLE);
  assign wr_ok     = idle && !bus.clr_req;
  assign sb_flush  = idle && bus.clr_req;
  assign sb_set_ok = wr_ok && bus.sb_set;
  assign bus.clr_busy = (state == SWEEP);

  always_comb begin
    wr_clr = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wa_a[j]  = bus.wa[slice_lo(j, ADDR_W) +: ADDR_W];
      wd_a[j]  = bus.wd[slice_lo(j, DATA_W) +: DATA_W];
      wr_go[j] = wr_ok && bus.we[j] && (wa_a[j] != ADDR_W'(REG_ZERO));
      if (wr_go[j]) wr_clr[wa_a[j]] = 1'b1;
    end
  end

  always_comb begin
    bus.rd  = '0;
    byp_hit = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra_a[i] = bus.ra[slice_lo(i, ADDR_W) +: ADDR_W];
      rd_a[i] = regs[ra_a[i]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest write port wins on a multi-hit.
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_go[j] && (wa_a[j] == ra_a[i])) begin
          rd_a[i]    = wd_a[j];
          byp_hit[i] = 1'b1;
        end
      end
`endif
      if (ra_a[i] == ADDR_W'(REG_ZERO)) rd_a[i] = '0;
      bus.rd[slice_lo(i, DATA_W) +: DATA_W] = rd_a[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= SWEEP;
            cnt   <= (ADDR_W+1)'(1);
          end
          for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_go[j]) regs[wa_a[j]] <= wd_a[j];
          end
        end
        SWEEP: begin
          regs[cnt[ADDR_W-1:0]] <= '0;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .NUM_RD  (NUM_RD),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .flush   (sb_flush),
    .set_en  (sb_set_ok),
    .set_addr(bus.sb_addr),
    .clr_vec (wr_clr),
    .ra      (bus.ra),
    .rd_mask (byp_hit),
    .rd_pend (bus.rd_pend)
  );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port CPU register file, the successor to the single-issue 2R/1W file used in the MIPS datapath.
- Adds configurable width, depth, read and write port counts, and same-cycle write-to-read bypass.
- Adds a pending-write scoreboard that tracks in-flight loads for hazard detection.
- Adds a sequential clear engine that sweeps the array on request.
- Sits between the decode stage (reads, scoreboard set) and the writeback stage (writes).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, register count; power of two, >= 4
NUM_RD, 2, number of read ports, 1..4
NUM_WR, 2, number of write ports, 1..2
ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ra  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data, combinational from ra
rd_pend  out  NUM_RD  pending-write flag per read port, combinational
we  in  NUM_WR  write enables
wa  in  NUM_WR*ADDR_W  write addresses
wd  in  NUM_WR*DATA_W  write data
sb_set  in  1  mark register sb_addr as pending (load issued)
sb_addr  in  ADDR_W  scoreboard set address
clr_req  in  1  start clear sweep (single-cycle pulse)
clr_busy  out  1  clear sweep in progress

Behaviour:
- Reset: synchronous, active-high; while rst=1 at a clock edge:
  - all registers <= 0, all pending bits <= 0
  - FSM <= IDLE, clr_busy = 0, sweep counter <= 0
  - rst overrides clr_req, we and sb_set in the same cycle.
- Register 0:
  - always reads 0; never marked pending
  - writes and sb_set to address 0 are ignored.
- Reads: combinational, zero latency; all NUM_RD ports are independent.
- Writes: take effect at the clock edge where we[j]=1.
  - If both ports target the same nonzero address, port NUM_WR-1 wins.
- Bypass (only when REGFILE_BYPASS_EN is defined): rd[i] returns wd[j] when we[j]=1, wa[j]==ra[i] and ra[i]!=0.
  - Highest j wins on a multi-hit.
- Scoreboard, one bit per register:
  - sb_set to addr A sets pend[A].
  - Any accepted write to A clears pend[A].
  - If sb_set and a write target the same A in one cycle, set wins and the bit stays 1.
  - rd_pend[i] = pend[ra[i]], forced to 0 when ra[i]=0.
  - With bypass enabled, rd_pend[i] is also forced to 0 when a same-cycle bypass hit exists for port i.
- Clear FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on clr_req: the counter loads 1, all pend bits clear at that edge, and clr_busy = 1 from the next cycle.
  - SWEEP: writes 0 to reg[counter], then increments the counter. Takes exactly NUM_REGS-1 cycles.
  - SWEEP -> IDLE after reg[NUM_REGS-1] is cleared; no wrap-around.
  - During SWEEP:
    - we and sb_set are ignored; the producer must stall on clr_busy
    - clr_req is ignored
    - reads return current array contents; bypass is disabled.
  - A clr_req in the same cycle as a write: the write is dropped.
  - Reset mid-sweep: immediate return to IDLE with everything zeroed.
- Widths: all arithmetic is on ADDR_W-bit indices. The counter is ADDR_W+1 bits so the terminal compare does not overflow.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-through bypass and rd_pend masking as described in Behaviour.
- Undefined: reads return array contents only, so a write is visible from the next cycle. rd_pend is never masked by an in-flight write.

Decomposition:
- Package regfile_pkg holds:
  - clear FSM state enum (IDLE, SWEEP)
  - localparam REG_ZERO = 0
  - default DATA_W and NUM_REGS constants
  - function for port-slice extraction.
- Sub-module regfile_scoreboard:
  - NUM_REGS pending bits, set/clear priority, flush input
  - read-port lookup for rd_pend.
- The array, bypass and clear FSM stay in regfile_mp.

Test Plan:
- Reset with rst=1 for 2 cycles after prior writes -> every rd = 0, rd_pend = 0, clr_busy = 0.
- we[0]=1, wa[0]=5, wd[0]=0xDEADBEEF; ra0=5 in the same cycle -> rd0 = 0xDEADBEEF when bypass is enabled, old value when it is not. Next cycle rd0 = 0xDEADBEEF either way.
- Both ports write address 7 (0x11 on port 0, 0x22 on port 1) -> next cycle rd = 0x22. A write of 0x55 to address 0 -> rd for address 0 stays 0.
- sb_set to address 9 -> rd_pend = 1 for ra=9. A later write to 9 clears it. A simultaneous sb_set and write to 9 -> rd_pend stays 1.
- Load all regs with nonzero values, pulse clr_req -> clr_busy high for exactly NUM_REGS-1 = 31 cycles. A write attempt to reg 3 mid-sweep is ignored. Afterwards all regs read 0.
- rst asserted 10 cycles into a sweep -> next cycle clr_busy = 0 and all regs read 0. A new clr_req afterwards restarts the sweep at reg 1.
